// File: rtl/huffman_scan_controller_if.sv
// Block-in / symbol-out handshake bundle for the Huffman scan controller.
interface huffman_scan_controller_if #(
  parameter int unsigned COEF_W   = 10,
  parameter int unsigned NUM_COEF = 64,
  parameter int unsigned COMP_W   = 2
);
  logic                         blk_valid;
  logic                         blk_ready;
  logic [NUM_COEF*COEF_W-1:0]   blk_coefs;
  logic [COMP_W-1:0]            blk_comp;
  logic                         pred_clear;
  logic                         sym_valid;
  logic                         sym_ready;
  logic                         sym_is_dc;
  logic [3:0]                   sym_run;
  logic [3:0]                   sym_size;
  logic [COEF_W:0]              sym_amp;
  logic [COMP_W-1:0]            sym_comp;
  logic                         sym_last;
  logic                         busy;

  modport master (
    output blk_valid, blk_coefs, blk_comp, pred_clear, sym_ready,
    input  blk_ready, sym_valid, sym_is_dc, sym_run, sym_size, sym_amp, sym_comp, sym_last, busy
  );

  modport slave (
    input  blk_valid, blk_coefs, blk_comp, pred_clear, sym_ready,
    output blk_ready, sym_valid, sym_is_dc, sym_run, sym_size, sym_amp, sym_comp, sym_last, busy
  );
endinterface

// File: rtl/huffman_scan_controller.sv
// JPEG Huffman scan controller: per-component DC prediction and AC
// (run, size, amplitude) symbol generation with ZRL and EOB insertion.
module huffman_scan_controller #(
  parameter int unsigned COEF_W   = 10,
  parameter int unsigned NUM_COEF = 64,
  parameter int unsigned NUM_COMP = 3,
  parameter int unsigned COMP_W   = 2
) (
  input logic                      clock,
  input logic                      reset_n,
  huffman_scan_controller_if.slave bus
);
  localparam int unsigned AMP_W = COEF_W + 1;
  localparam int unsigned K_W   = $clog2(NUM_COEF);
  localparam int unsigned ZR_W  = 7;

  typedef enum logic [2:0] {IDLE, DC, SCAN, ZRL, AC, EOB} state_t;

  state_t                   state_q, state_d;
  logic signed [COEF_W-1:0] coef_q [NUM_COEF];
  logic signed [COEF_W-1:0] pred_q [NUM_COMP];
  logic [K_W-1:0]           k_q, k_d;
  logic [ZR_W-1:0]          zrun_q, zrun_d;

  logic              sym_valid_q, sym_valid_d;
  logic              sym_is_dc_q, sym_is_dc_d;
  logic [3:0]        sym_run_q, sym_run_d;
  logic [3:0]        sym_size_q, sym_size_d;
  logic [AMP_W-1:0]  sym_amp_q, sym_amp_d;
  logic [COMP_W-1:0] sym_comp_q, sym_comp_d;
  logic              sym_last_q, sym_last_d;
  logic              blk_ready_q, busy_q;

  logic signed [COEF_W-1:0] coef0, pred_eff, cur;
  logic signed [AMP_W-1:0]  diff;
  logic [AMP_W+3:0]         dc_enc, ac_enc;
  logic                     comp_ok, accept, sym_hs, k_last;
  logic [ZR_W-1:0]          zrun_m16;

  // Magnitude category in the top 4 bits, amplitude bits below.
  function automatic logic [AMP_W+3:0] enc(input logic signed [AMP_W-1:0] v);
    logic [AMP_W-1:0] mag, mask, amp;
    logic [3:0]       sz;
    mag = v[AMP_W-1] ? AMP_W'(-v) : AMP_W'(v);
    sz  = '0;
    for (int i = 0; i < int'(AMP_W); i++) if (mag[i]) sz = 4'(i + 1);
    mask = '0;
    for (int i = 0; i < int'(AMP_W); i++) if (i < int'(sz)) mask[i] = 1'b1;
    amp = v[AMP_W-1] ? ((AMP_W'(v) - AMP_W'(1)) & mask) : AMP_W'(v);
    return {sz, amp};
  endfunction

  assign coef0    = bus.blk_coefs[COEF_W-1:0];
  assign comp_ok  = 32'(bus.blk_comp) < NUM_COMP;
  assign pred_eff = (bus.pred_clear || !comp_ok) ? '0 : pred_q[bus.blk_comp];
  assign diff     = AMP_W'(coef0) - AMP_W'(pred_eff);
  assign cur      = coef_q[k_q];
  assign dc_enc   = enc(diff);
  assign ac_enc   = enc(AMP_W'(cur));
  assign accept   = bus.blk_valid & blk_ready_q;
  assign sym_hs   = sym_valid_q & bus.sym_ready;
  assign k_last   = (k_q == K_W'(NUM_COEF - 1));
  assign zrun_m16 = zrun_q - ZR_W'(16);

  // Next state and next symbol; symbol fields hold unless a new one is loaded.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    zrun_d      = zrun_q;
    sym_valid_d = sym_valid_q;
    sym_is_dc_d = sym_is_dc_q;
    sym_run_d   = sym_run_q;
    sym_size_d  = sym_size_q;
    sym_amp_d   = sym_amp_q;
    sym_comp_d  = sym_comp_q;
    sym_last_d  = sym_last_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d                = DC;
        sym_valid_d            = 1'b1;
        sym_is_dc_d            = 1'b1;
        sym_run_d              = '0;
        {sym_size_d, sym_amp_d} = dc_enc;
        sym_comp_d             = bus.blk_comp;
        sym_last_d             = 1'b0;
      end
      DC: if (sym_hs) begin
        state_d     = SCAN;
        sym_valid_d = 1'b0;
        sym_is_dc_d = 1'b0;
        k_d         = K_W'(1);
        zrun_d      = '0;
      end
      SCAN: begin
        if (cur == '0) begin
          zrun_d = zrun_q + ZR_W'(1);
          if (k_last) begin
            state_d     = EOB;
            sym_valid_d = 1'b1;
            sym_run_d   = '0;
            sym_size_d  = '0;
            sym_amp_d   = '0;
            sym_last_d  = 1'b1;
          end else begin
            k_d = k_q + K_W'(1);
          end
        end else if (zrun_q >= ZR_W'(16)) begin
          state_d     = ZRL;
          sym_valid_d = 1'b1;
          sym_run_d   = 4'd15;
          sym_size_d  = '0;
          sym_amp_d   = '0;
          sym_last_d  = 1'b0;
        end else begin
          state_d                 = AC;
          sym_valid_d             = 1'b1;
          sym_run_d               = 4'(zrun_q);
          {sym_size_d, sym_amp_d} = ac_enc;
          sym_last_d              = k_last;
        end
      end
      // Repeated ZRLs go out back-to-back with the same symbol held.
      ZRL: if (sym_hs) begin
        zrun_d = zrun_m16;
        if (zrun_m16 < ZR_W'(16)) begin
          state_d                 = AC;
          sym_run_d               = 4'(zrun_m16);
          {sym_size_d, sym_amp_d} = ac_enc;
          sym_last_d              = k_last;
        end
      end
      AC: if (sym_hs) begin
        sym_valid_d = 1'b0;
        if (k_last) begin
          state_d = IDLE;
        end else begin
          state_d = SCAN;
          zrun_d  = '0;
          k_d     = k_q + K_W'(1);
        end
      end
      EOB: if (sym_hs) begin
        state_d     = IDLE;
        sym_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      zrun_q      <= '0;
      sym_valid_q <= 1'b0;
      sym_is_dc_q <= 1'b0;
      sym_run_q   <= '0;
      sym_size_q  <= '0;
      sym_amp_q   <= '0;
      sym_comp_q  <= '0;
      sym_last_q  <= 1'b0;
      blk_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      zrun_q      <= zrun_d;
      sym_valid_q <= sym_valid_d;
      sym_is_dc_q <= sym_is_dc_d;
      sym_run_q   <= sym_run_d;
      sym_size_q  <= sym_size_d;
      sym_amp_q   <= sym_amp_d;
      sym_comp_q  <= sym_comp_d;
      sym_last_q  <= sym_last_d;
      blk_ready_q <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
    end
  end

  // Block latch and predictors; a same-cycle clear lands before the update.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NUM_COEF); i++) coef_q[i] <= '0;
      for (int i = 0; i < int'(NUM_COMP); i++) pred_q[i] <= '0;
    end else begin
      if (bus.pred_clear) begin
        for (int i = 0; i < int'(NUM_COMP); i++) pred_q[i] <= '0;
      end
      if (accept) begin
        for (int i = 0; i < int'(NUM_COEF); i++) coef_q[i] <= bus.blk_coefs[i*COEF_W +: COEF_W];
        if (comp_ok) pred_q[bus.blk_comp] <= coef0;
      end
    end
  end

  assign bus.blk_ready = blk_ready_q;
  assign bus.busy      = busy_q;
  assign bus.sym_valid = sym_valid_q;
  assign bus.sym_is_dc = sym_is_dc_q;
  assign bus.sym_run   = sym_run_q;
  assign bus.sym_size  = sym_size_q;
  assign bus.sym_amp   = sym_amp_q;
  assign bus.sym_comp  = sym_comp_q;
  assign bus.sym_last  = sym_last_q;
endmodule

// File: tb/tb_huffman_scan_controller.sv
// Bench for huffman_scan_controller: directed scenarios plus randomized blocks
// checked against a list-based symbol model.
module tb_huffman_scan_controller;
  localparam int unsigned COEF_W   = 10;
  localparam int unsigned NUM_COEF = 64;
  localparam int unsigned NUM_COMP = 3;
  localparam int unsigned COMP_W   = 2;
  localparam int unsigned AMP_W    = COEF_W + 1;

  typedef struct packed {
    logic              is_dc;
    logic [3:0]        run;
    logic [3:0]        size;
    logic [AMP_W-1:0]  amp;
    logic [COMP_W-1:0] comp;
    logic              last;
  } sym_t;

  logic clock;
  logic reset_n;

  huffman_scan_controller_if #(.COEF_W(COEF_W), .NUM_COEF(NUM_COEF), .COMP_W(COMP_W)) bus ();

  huffman_scan_controller #(.COEF_W(COEF_W), .NUM_COEF(NUM_COEF), .NUM_COMP(NUM_COMP), .COMP_W(COMP_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cf [NUM_COEF];
  int   mpred [NUM_COMP];
  sym_t got_q[$];
  sym_t exp_q[$];
  bit   timed_out;
  bit   done;
  int   first_valid, acc_cyc, stable_err, ready_err;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic sym_t mk(input bit dc, input int run, input int size, input int amp,
                              input int comp, input bit last);
    sym_t s;
    s.is_dc = dc;
    s.run   = 4'(run);
    s.size  = 4'(size);
    s.amp   = AMP_W'(amp);
    s.comp  = COMP_W'(comp);
    s.last  = last;
    return s;
  endfunction

  function automatic sym_t cur_sym();
    sym_t s;
    s.is_dc = bus.sym_is_dc;
    s.run   = bus.sym_run;
    s.size  = bus.sym_size;
    s.amp   = bus.sym_amp;
    s.comp  = bus.sym_comp;
    s.last  = bus.sym_last;
    return s;
  endfunction

  function automatic logic [NUM_COEF*COEF_W-1:0] pack_cf();
    logic [NUM_COEF*COEF_W-1:0] v;
    v = '0;
    for (int i = 0; i < int'(NUM_COEF); i++) v[i*COEF_W +: COEF_W] = COEF_W'(cf[i]);
    return v;
  endfunction

  // Size = number of bits in |v|; negative amplitude is v + 2^size - 1.
  function automatic void size_amp(input int v, output int s, output int a);
    int m;
    m = (v < 0) ? -v : v;
    s = 0;
    while (m > 0) begin s++; m = m >> 1; end
    a = (v >= 0) ? v : v + (1 << s) - 1;
  endfunction

  // Reference symbol list for the block in cf[], updating the model predictors.
  function automatic void build_expect(input int comp, input bit clr, input bit mid_clr);
    int diff, s, a, run;
    exp_q.delete();
    diff = cf[0] - (clr ? 0 : mpred[comp]);
    if (clr) foreach (mpred[i]) mpred[i] = 0;
    mpred[comp] = cf[0];
    if (mid_clr) foreach (mpred[i]) mpred[i] = 0;
    size_amp(diff, s, a);
    exp_q.push_back(mk(1, 0, s, a, comp, 0));
    run = 0;
    for (int i = 1; i < int'(NUM_COEF); i++) begin
      if (cf[i] == 0) run++;
      else begin
        while (run >= 16) begin exp_q.push_back(mk(0, 15, 0, 0, comp, 0)); run -= 16; end
        size_amp(cf[i], s, a);
        exp_q.push_back(mk(0, run, s, a, comp, i == int'(NUM_COEF) - 1));
        run = 0;
      end
    end
    if (cf[NUM_COEF-1] == 0) exp_q.push_back(mk(0, 0, 0, 0, comp, 1));
  endfunction

  // Offer cf[] as one block and collect its symbols; starts and ends on a falling edge.
  task automatic send_block(input int comp, input bit clr, input bit mid_clr, input int rdy_pct);
    bit   acc, will_acc, stall_prev;
    sym_t held;
    build_expect(comp, clr, mid_clr);
    got_q.delete();
    acc = 0; done = 0; stall_prev = 0; held = '0;
    first_valid = -1; acc_cyc = -1; stable_err = 0; ready_err = 0;
    bus.blk_coefs = pack_cf();
    bus.blk_comp  = COMP_W'(comp);
    bus.blk_valid = 1'b1;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      if (acc && first_valid < 0 && bus.sym_valid) first_valid = cyc - acc_cyc;
      if (stall_prev && (!bus.sym_valid || cur_sym() !== held)) stable_err++;
      if (acc && (bus.blk_ready || !bus.busy)) ready_err++;
      bus.sym_ready  = (int'($urandom_range(99)) < rdy_pct);
      will_acc       = !acc && bus.blk_ready;
      bus.pred_clear = (will_acc && clr) || (acc && mid_clr && cyc == acc_cyc + 3);
      if (bus.sym_valid && bus.sym_ready) begin
        got_q.push_back(cur_sym());
        if (bus.sym_last) done = 1;
      end
      stall_prev = bus.sym_valid && !bus.sym_ready;
      held       = cur_sym();
      @(posedge clock);
      @(negedge clock);
      bus.pred_clear = 1'b0;
      if (will_acc) begin acc = 1; acc_cyc = cyc; bus.blk_valid = 1'b0; end
    end
    timed_out      = !done;
    bus.blk_valid  = 1'b0;
    bus.sym_ready  = 1'b0;
    bus.pred_clear = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n        = 1'b0;
    bus.blk_valid  = 1'b0;
    bus.blk_coefs  = '0;
    bus.blk_comp   = '0;
    bus.pred_clear = 1'b0;
    bus.sym_ready  = 1'b0;
    foreach (mpred[i]) mpred[i] = 0;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (cur_sym() !== '0 || bus.sym_valid !== 1'b0) $display("FAIL reset_sym: got valid=%b sym=%h want 0", bus.sym_valid, cur_sym());
    else n_pass++;
    n_checks++;
    if (bus.blk_ready !== 1'b0 || bus.busy !== 1'b0) $display("FAIL reset_ctrl: got ready=%b busy=%b want 0 0", bus.blk_ready, bus.busy);
    else n_pass++;
    reset_n = 1'b1;
    @(negedge clock);
    n_checks++;
    if (bus.blk_ready !== 1'b1 || bus.busy !== 1'b0 || bus.sym_valid !== 1'b0)
      $display("FAIL post_reset_idle: got ready=%b busy=%b valid=%b want 1 0 0", bus.blk_ready, bus.busy, bus.sym_valid);
    else n_pass++;
  endtask

  task automatic test_zero_block();
    sym_t want[2];
    sym_t g;
    want[0] = mk(1, 0, 0, 0, 0, 0);
    want[1] = mk(0, 0, 0, 0, 0, 1);
    foreach (cf[i]) cf[i] = 0;
    send_block(0, 0, 0, 100);
    n_checks++;
    if (timed_out || got_q.size() != 2) $display("FAIL zero_block_count: got %0d symbols (timeout=%b) want 2", got_q.size(), timed_out);
    else n_pass++;
    n_checks++;
    if (first_valid !== 1) $display("FAIL zero_block_dc_latency: got %0d want 1", first_valid);
    else n_pass++;
    foreach (want[i]) begin
      g = (i < got_q.size()) ? got_q[i] : '0;
      n_checks++;
      if (g !== want[i]) $display("FAIL zero_block_sym%0d: got %h want %h", i, g, want[i]);
      else n_pass++;
    end
    n_checks++;
    if (bus.blk_ready !== 1'b1 || bus.busy !== 1'b0) $display("FAIL zero_block_ready_back: got ready=%b busy=%b want 1 0", bus.blk_ready, bus.busy);
    else n_pass++;
  endtask

  task automatic test_dc_predictor();
    int   dcv[3] = '{5, 3, 3};
    int   cmp[3] = '{1, 1, 2};
    sym_t want[3];
    sym_t g;
    want[0] = mk(1, 0, 3, 5, 1, 0);
    want[1] = mk(1, 0, 2, 1, 1, 0);
    want[2] = mk(1, 0, 2, 3, 2, 0);
    for (int j = 0; j < 3; j++) begin
      foreach (cf[i]) cf[i] = 0;
      cf[0] = dcv[j];
      send_block(cmp[j], 0, 0, 100);
      g = (got_q.size() > 0) ? got_q[0] : '0;
      n_checks++;
      if (timed_out || got_q.size() != 2 || g !== want[j]) $display("FAIL dc_pred_blk%0d: got %h (n=%0d) want %h (n=2)", j, g, got_q.size(), want[j]);
      else n_pass++;
    end
  endtask

  task automatic test_ac_zrl();
    sym_t want[5];
    sym_t g;
    want[0] = mk(1, 0, 0, 0, 0, 0);
    want[1] = mk(0, 0, 1, 0, 0, 0);
    want[2] = mk(0, 15, 0, 0, 0, 0);
    want[3] = mk(0, 2, 3, 7, 0, 0);
    want[4] = mk(0, 0, 0, 0, 0, 1);
    foreach (cf[i]) cf[i] = 0;
    cf[1] = -1; cf[20] = 7;
    send_block(0, 0, 0, 100);
    n_checks++;
    if (timed_out || got_q.size() != 5) $display("FAIL ac_zrl_count: got %0d want 5", got_q.size());
    else n_pass++;
    foreach (want[i]) begin
      g = (i < got_q.size()) ? got_q[i] : '0;
      n_checks++;
      if (g !== want[i]) $display("FAIL ac_zrl_sym%0d: got %h want %h", i, g, want[i]);
      else n_pass++;
    end
  endtask

  task automatic test_long_run();
    sym_t want[5];
    sym_t g;
    want[0] = mk(1, 0, 0, 0, 0, 0);
    want[1] = mk(0, 15, 0, 0, 0, 0);
    want[2] = mk(0, 15, 0, 0, 0, 0);
    want[3] = mk(0, 15, 0, 0, 0, 0);
    want[4] = mk(0, 14, 1, 1, 0, 1);
    foreach (cf[i]) cf[i] = 0;
    cf[NUM_COEF-1] = 1;
    send_block(0, 0, 0, 100);
    n_checks++;
    if (timed_out || got_q.size() != 5) $display("FAIL long_run_count: got %0d want 5", got_q.size());
    else n_pass++;
    foreach (want[i]) begin
      g = (i < got_q.size()) ? got_q[i] : '0;
      n_checks++;
      if (g !== want[i]) $display("FAIL long_run_sym%0d: got %h want %h", i, g, want[i]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    sym_t want[5];
    sym_t g;
    want[0] = mk(1, 0, 0, 0, 0, 0);
    want[1] = mk(0, 0, 1, 0, 0, 0);
    want[2] = mk(0, 15, 0, 0, 0, 0);
    want[3] = mk(0, 2, 3, 7, 0, 0);
    want[4] = mk(0, 0, 0, 0, 0, 1);
    for (int r = 0; r < 3; r++) begin
      foreach (cf[i]) cf[i] = 0;
      cf[1] = -1; cf[20] = 7;
      send_block(0, 0, 0, 50);
      n_checks++;
      if (timed_out || got_q.size() != 5) $display("FAIL stall_count_r%0d: got %0d want 5", r, got_q.size());
      else n_pass++;
      foreach (want[i]) begin
        g = (i < got_q.size()) ? got_q[i] : '0;
        n_checks++;
        if (g !== want[i]) $display("FAIL stall_sym%0d_r%0d: got %h want %h", i, r, g, want[i]);
        else n_pass++;
      end
      n_checks++;
      if (stable_err != 0 || ready_err != 0) $display("FAIL stall_hold_r%0d: got %0d unstable, %0d ready/busy errors want 0 0", r, stable_err, ready_err);
      else n_pass++;
      n_checks++;
      if (acc_cyc != 0) $display("FAIL back_to_back_accept_r%0d: got wait %0d want 0", r, acc_cyc);
      else n_pass++;
    end
  endtask

  task automatic test_pred_clear();
    int   dcv[4] = '{9, 4, 4, 3};
    int   cmp[4] = '{0, 0, 0, 1};
    bit   clr[4] = '{0, 1, 0, 0};
    sym_t want[4];
    sym_t g;
    want[0] = mk(1, 0, 4, 9, 0, 0);
    want[1] = mk(1, 0, 3, 4, 0, 0);
    want[2] = mk(1, 0, 0, 0, 0, 0);
    want[3] = mk(1, 0, 2, 3, 1, 0);
    for (int j = 0; j < 4; j++) begin
      foreach (cf[i]) cf[i] = 0;
      cf[0] = dcv[j];
      send_block(cmp[j], clr[j], 0, 100);
      g = (got_q.size() > 0) ? got_q[0] : '0;
      n_checks++;
      if (timed_out || g !== want[j]) $display("FAIL pred_clear_blk%0d: got %h want %h", j, g, want[j]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic signed [COEF_W-1:0] t;
    int   mode, comp, pct;
    bit   clr, mclr;
    sym_t g;
    for (int b = 0; b < 24; b++) begin
      mode = int'($urandom_range(2));
      foreach (cf[i]) begin
        t = COEF_W'($urandom);
        if (i == 0) cf[i] = int'(t);
        else if (mode == 0) cf[i] = ($urandom_range(99) < 30) ? (int'(t) >>> $urandom_range(COEF_W - 1)) : 0;
        else if (mode == 1) cf[i] = ($urandom_range(99) < 4) ? int'(t) : 0;
        else cf[i] = (i == int'(NUM_COEF) - 1) ? int'(t) : 0;
      end
      comp = int'($urandom_range(NUM_COMP - 1));
      clr  = ($urandom_range(6) == 0);
      mclr = ($urandom_range(6) == 0);
      pct  = (b % 2 == 1) ? 45 : 100;
      send_block(comp, clr, mclr, pct);
      n_checks++;
      if (timed_out || got_q.size() != exp_q.size()) $display("FAIL rand%0d_count: got %0d want %0d", b, got_q.size(), exp_q.size());
      else n_pass++;
      foreach (exp_q[i]) begin
        g = (i < got_q.size()) ? got_q[i] : '0;
        n_checks++;
        if (g !== exp_q[i]) $display("FAIL rand%0d_sym%0d: got %h want %h", b, i, g, exp_q[i]);
        else n_pass++;
      end
      n_checks++;
      if (stable_err != 0 || ready_err != 0) $display("FAIL rand%0d_hold: got %0d unstable, %0d ready/busy errors want 0 0", b, stable_err, ready_err);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    sym_t g;
    int   w;
    foreach (cf[i]) cf[i] = 0;
    cf[0] = 6; cf[40] = 3;
    send_block(1, 0, 0, 100);
    bus.blk_coefs = pack_cf();
    bus.blk_comp  = COMP_W'(1);
    bus.blk_valid = 1'b1;
    bus.sym_ready = 1'b0;
    w = 0;
    while (!bus.blk_ready && w < 20) begin @(negedge clock); w++; end
    @(negedge clock);
    bus.blk_valid = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++;
    if (bus.sym_valid !== 1'b1 || bus.busy !== 1'b1) $display("FAIL mid_block_stalled: got valid=%b busy=%b want 1 1", bus.sym_valid, bus.busy);
    else n_pass++;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.sym_valid !== 1'b0 || cur_sym() !== '0 || bus.busy !== 1'b0 || bus.blk_ready !== 1'b0)
      $display("FAIL mid_reset_outputs: got valid=%b sym=%h busy=%b ready=%b want all 0", bus.sym_valid, cur_sym(), bus.busy, bus.blk_ready);
    else n_pass++;
    @(negedge clock);
    reset_n = 1'b1;
    foreach (mpred[i]) mpred[i] = 0;
    foreach (cf[i]) cf[i] = 0;
    cf[0] = 6;
    send_block(1, 0, 0, 100);
    g = (got_q.size() > 0) ? got_q[0] : '0;
    n_checks++;
    if (timed_out || g !== mk(1, 0, 3, 6, 1, 0)) $display("FAIL mid_reset_pred_zero: got %h want %h", g, mk(1, 0, 3, 6, 1, 0));
    else n_pass++;
  endtask

  initial begin
    reset_n        = 1'b1;
    bus.blk_valid  = 1'b0;
    bus.blk_coefs  = '0;
    bus.blk_comp   = '0;
    bus.pred_clear = 1'b0;
    bus.sym_ready  = 1'b0;
    test_reset();
    test_zero_block();
    test_dc_predictor();
    test_ac_zrl();
    test_long_run();
    test_back_to_back();
    test_pred_clear();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
